// File: rtl/config_uart_loader_if.sv
// Configuration-word output bundle of the UART configuration loader.
//   WriteData   assembled configuration word, first received byte in the MSBs
//   WriteStrobe one-cycle pulse, WriteData valid in the same cycle
//   Command     last accepted command byte
//   ComActive   high while payload bytes are expected
//   Done        one-cycle pulse after the checksum field has been received
//   ChecksumOk  checksum result of the last completed frame
//   ErrCode     0 none, 1 framing, 2 timeout, 3 checksum mismatch
// master: the loader (drives everything); slave: the frame writer.
interface config_uart_loader_if #(
  parameter int WORD_WIDTH = 32
);
  logic [WORD_WIDTH-1:0] WriteData;
  logic                  WriteStrobe;
  logic [7:0]            Command;
  logic                  ComActive;
  logic                  Done;
  logic                  ChecksumOk;
  logic [1:0]            ErrCode;

  modport master (
    output WriteData, WriteStrobe, Command, ComActive, Done, ChecksumOk, ErrCode
  );

  modport slave (
    input WriteData, WriteStrobe, Command, ComActive, Done, ChecksumOk, ErrCode
  );
endinterface

// File: rtl/config_uart_loader.sv
// UART configuration loader: receives 8N1 bytes on Rx, hunts for a 3-byte sync
// preamble, reads command and 16-bit length, then assembles the (bin or hex
// encoded) payload into WORD_WIDTH-bit words and verifies a 16-bit sum.
// Ports:
//   CLK     clock
//   resetn  asynchronous active-low reset
//   Rx      UART serial input, idle high, asynchronous to CLK
//   bus     config_uart_loader_if.master (words, status, errors)
module config_uart_loader #(
  parameter int          WORD_WIDTH     = 32,
  parameter int          CLKS_PER_BIT   = 217,
  parameter int          MODE           = 0,
  parameter int          TIMEOUT_CYCLES = 16777,
  parameter logic [23:0] SYNC_WORD      = 24'h00AAFF
) (
  input  logic                 CLK,
  input  logic                 resetn,
  input  logic                 Rx,
  config_uart_loader_if.master bus
);

  localparam int BPW = WORD_WIDTH / 8;
  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int WCW = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
  typedef enum logic [3:0] {IDLE, SYNC1, SYNC2, CMD, LEN_H, LEN_L, EVAL, DATA, CK, FIN} state_t;

  function automatic logic is_hex(input logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) ||
           (c >= 8'h61 && c <= 8'h66);
  endfunction

  // Letters sit at 0x41/0x61 upwards, so their low nibble plus 9 gives 10..15.
  function automatic logic [3:0] hex_nib(input logic [7:0] c);
    return (c <= 8'h39) ? c[3:0] : c[3:0] + 4'd9;
  endfunction

  rx_state_t rx_state, rx_next;
  logic          rx_s1, rx_s2;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    rx_shift;
  logic          byte_vld, frame_err;
  logic          tick;

  state_t state, nxt;
  logic [15:0]           len, byte_cnt, sum, exp_sum;
  logic [WORD_WIDTH-1:0] word_sr, word_nxt;
  logic [WCW-1:0]        wcnt;
  logic                  ck_cnt, nib_lo;
  logic [3:0]            nib_hi;
  logic [TW-1:0]         to_cnt;
  logic                  hex_mode, len_ok, timeout, dec_vld;
  logic [7:0]            dec_byte;

  // Receiver: synchroniser and bit timing
  assign tick = (bit_cnt == '0);

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) rx_state <= RX_IDLE;
    else         rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (!rx_s2) rx_next = RX_START;
      RX_START: if (tick) rx_next = rx_s2 ? RX_IDLE : RX_DATA;   // high = glitch
      RX_DATA:  if (tick && bit_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (tick) rx_next = rx_s2 ? RX_IDLE : RX_WAIT;
      RX_WAIT:  if (rx_s2) rx_next = RX_IDLE;                    // re-arm on high line
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      rx_shift  <= '0;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_s1     <= Rx;
      rx_s2     <= rx_s1;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
      if (rx_state == RX_IDLE)  bit_cnt <= CW'(CLKS_PER_BIT / 2);
      else if (tick)            bit_cnt <= CW'(CLKS_PER_BIT - 1);
      else                      bit_cnt <= bit_cnt - CW'(1);
      if (rx_state == RX_START) bit_idx <= '0;
      if (rx_state == RX_DATA && tick) begin
        rx_shift <= {rx_s2, rx_shift[7:1]};
        bit_idx  <= bit_idx + 3'd1;
      end
      if (rx_state == RX_STOP && tick) begin
        byte_vld  <= rx_s2;
        frame_err <= !rx_s2;
      end
    end
  end

  // Frame decode: payload byte reconstruction
  assign hex_mode = (MODE == 1) ? 1'b1 : (MODE == 2) ? 1'b0 : bus.Command[7];
  assign len_ok   = (bus.Command[6:0] == 7'd1 || bus.Command[6:0] == 7'd2) &&
                    (len != 16'd0) && ((len % 16'(BPW)) == 16'd0);
  assign timeout  = (to_cnt == '0) && (state != IDLE) && !byte_vld;
  assign word_nxt = WORD_WIDTH'({word_sr, dec_byte});

  always_comb begin
    dec_vld  = 1'b0;
    dec_byte = rx_shift;
    if (byte_vld && (state == DATA || state == CK)) begin
      if (!hex_mode) begin
        dec_vld = 1'b1;
      end else if (is_hex(rx_shift) && nib_lo) begin
        dec_vld  = 1'b1;
        dec_byte = {nib_hi, hex_nib(rx_shift)};
      end
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= nxt;
  end

  always_comb begin
    nxt = state;
    if ((frame_err && state != IDLE) || timeout) begin
      nxt = IDLE;
    end else begin
      case (state)
        IDLE:  if (byte_vld && rx_shift == SYNC_WORD[23:16]) nxt = SYNC1;
        SYNC1: if (byte_vld) nxt = (rx_shift == SYNC_WORD[15:8])  ? SYNC2 :
                                   (rx_shift == SYNC_WORD[23:16]) ? SYNC1 : IDLE;
        SYNC2: if (byte_vld) nxt = (rx_shift == SYNC_WORD[7:0])   ? CMD   :
                                   (rx_shift == SYNC_WORD[23:16]) ? SYNC1 : IDLE;
        CMD:   if (byte_vld) nxt = LEN_H;
        LEN_H: if (byte_vld) nxt = LEN_L;
        LEN_L: if (byte_vld) nxt = EVAL;
        EVAL:  nxt = len_ok ? DATA : IDLE;
        DATA:  if (dec_vld && byte_cnt == len - 16'd1) nxt = CK;
        CK:    if (dec_vld && ck_cnt) nxt = FIN;
        FIN:   nxt = IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  // Word assembly, checksum, status outputs
  assign bus.ComActive = (state == DATA);

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      bus.WriteData   <= '0;
      bus.WriteStrobe <= 1'b0;
      bus.Command     <= '0;
      bus.Done        <= 1'b0;
      bus.ChecksumOk  <= 1'b0;
      bus.ErrCode     <= '0;
      len             <= '0;
      byte_cnt        <= '0;
      sum             <= '0;
      exp_sum         <= '0;
      word_sr         <= '0;
      wcnt            <= '0;
      ck_cnt          <= 1'b0;
      nib_lo          <= 1'b0;
      nib_hi          <= '0;
      to_cnt          <= TW'(TIMEOUT_CYCLES);
    end else begin
      bus.WriteStrobe <= 1'b0;
      bus.Done        <= 1'b0;
      if (byte_vld || state == IDLE) to_cnt <= TW'(TIMEOUT_CYCLES);
      else if (to_cnt != '0)         to_cnt <= to_cnt - TW'(1);

      if (frame_err && state != IDLE) begin
        bus.ErrCode <= 2'd1;
      end else if (timeout) begin
        bus.ErrCode <= 2'd2;
      end else begin
        case (state)
          CMD: if (byte_vld) begin
            bus.Command    <= rx_shift;
            bus.ErrCode    <= 2'd0;
            bus.ChecksumOk <= 1'b0;
          end
          LEN_H: if (byte_vld) len[15:8] <= rx_shift;
          LEN_L: if (byte_vld) len[7:0]  <= rx_shift;
          EVAL: begin
            byte_cnt <= '0;
            sum      <= '0;
            exp_sum  <= '0;
            word_sr  <= '0;
            wcnt     <= '0;
            ck_cnt   <= 1'b0;
            nib_lo   <= 1'b0;
          end
          DATA, CK: begin
            // Non-hex characters leave the nibble phase untouched.
            if (byte_vld && hex_mode && is_hex(rx_shift)) begin
              nib_lo <= !nib_lo;
              if (!nib_lo) nib_hi <= hex_nib(rx_shift);
            end
            if (dec_vld && state == DATA) begin
              word_sr  <= word_nxt;
              sum      <= sum + {8'h00, dec_byte};
              byte_cnt <= byte_cnt + 16'd1;
              if (wcnt == WCW'(BPW - 1)) begin
                wcnt            <= '0;
                bus.WriteData   <= word_nxt;
                bus.WriteStrobe <= 1'b1;
              end else begin
                wcnt <= wcnt + WCW'(1);
              end
            end
            if (dec_vld && state == CK) begin
              exp_sum <= {exp_sum[7:0], dec_byte};
              ck_cnt  <= 1'b1;
            end
          end
          FIN: begin
            bus.Done       <= 1'b1;
            bus.ChecksumOk <= (sum == exp_sum);
            if (sum != exp_sum) bus.ErrCode <= 2'd3;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
